// File: rtl/sub_seq.sv
// Slice-serial subtractor: diff = op1 - op2 - bin, SLICE bits per BUSY cycle with a registered borrow.
// Define SUB_FLAGS_EN to add the registered zero/ovf result flags.
module sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1_in,
  input  logic [WIDTH-1:0] op2_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [1:0]       state_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("sub_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  op1_q;
  logic [WIDTH-1:0]  op2_q;
  logic              borrow_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WIDTH-1:0]  diff_q;
  logic              bout_q;
`ifdef SUB_FLAGS_EN
  logic              zero_q;
  logic              ovf_q;
`endif

  logic [SLICE:0]    slice_sum;
  logic [WIDTH-1:0]  diff_d;
  logic              borrow_d;
  logic              last_slice;

  // Subtraction as op1 + ~op2 + carry, where carry-in is the inverted borrow.
  always_comb begin
    slice_sum = {1'b0, op1_q[idx_q*SLICE +: SLICE]}
              + {1'b0, ~op2_q[idx_q*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, ~borrow_q};
    diff_d = diff_q;
    diff_d[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    borrow_d   = ~slice_sum[SLICE];
    last_slice = (idx_q == IDX_W'(NSLICE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op1_q    <= op1_in;
            op2_q    <= op2_in;
            borrow_q <= bin;
            idx_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          if (last_slice) begin
            idx_q   <= '0;
            bout_q  <= borrow_d;
`ifdef SUB_FLAGS_EN
            zero_q  <= (diff_d == '0);
            ovf_q   <= (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (diff_d[WIDTH-1] != op1_q[WIDTH-1]);
`endif
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign state_o   = state_q;
`ifdef SUB_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_seq.sv
// Directed and randomized checks of sub_seq at WIDTH=32, SLICE=8 (flag checks when SUB_FLAGS_EN is set).
module tb_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1_in;
  logic [31:0] op2_in;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  // {ovf, zero, bout, diff}
  logic [34:0] exp_q[$];

  sub_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1_in    (op1_in),
    .op2_in    (op2_in),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .state_o   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] r;
    @(negedge clk);
    check("send_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op1_in   = a;
    op2_in   = b;
    bin      = bi;
    r = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    exp_q.push_back({(a[31] != b[31]) && (r[31] != a[31]), (r[31:0] == 32'd0), r});
    @(posedge clk);
    @(negedge clk);
    // garbage on the inputs while busy must be ignored
    in_valid = 1'($urandom_range(0, 1));
    op1_in   = $urandom;
    op2_in   = $urandom;
    bin      = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input string tag, input int stall);
    int          lat;
    logic [34:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_diff"}, {32'd0, diff}, {32'd0, e[31:0]});
    check({tag, "_bout"}, {63'd0, bout}, {63'd0, e[32]});
    check({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
`ifdef SUB_FLAGS_EN
    check({tag, "_zero"}, {63'd0, zero}, {63'd0, e[33]});
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e[34]});
`endif
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {29'd0, out_valid, in_ready, bout, diff},
            {29'd0, 1'b1, 1'b0, e[32], e[31:0]});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_popped"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op1_in    = '0;
    op2_in    = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {29'd0, out_valid, in_ready, bout, diff}, {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
`ifdef SUB_FLAGS_EN
    check("reset_flags", {62'd0, zero, ovf}, 64'd0);
`endif
    rst_n = 1'b1;

    // 1: simple subtract, then idle hold
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    collect("t1", 0);
    repeat (3) @(negedge clk);
    check("t1_idle_hold", {29'd0, in_ready, out_valid, bout, diff}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0002});

    // 2: borrow ripples through all slices
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    collect("t2", 0);

    // 3: signed overflow case
    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    collect("t3", 1);

    // 4: borrow-in and zero result
    send(32'h0000_0005, 32'h0000_0005, 1'b1);
    collect("t4a", 0);
    send(32'h0000_1234, 32'h0000_1234, 1'b0);
    collect("t4b", 0);

    // 5: five cycles of backpressure in DONE
    send(32'h0000_1000, 32'h0000_0001, 1'b0);
    collect("t5", 5);

    // 6: reset while slice 2 is in flight
    send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_in_reset", {30'd0, out_valid, bout, diff}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_no_emit", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    end
    send(32'h0000_0100, 32'h0000_0200, 1'b0);
    collect("t6_after", 0);

    // random operands with random backpressure and idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 32'd0;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(a, b, 1'($urandom_range(0, 1)));
      collect("rand", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
